shift_add_multiplier: RTL and testbench

Iterative unsigned multiplier for the datapath. It sits beside the ALU, downstream of the operand source, and computes a WIDTH x WIDTH -> 2*WIDTH product by shift-and-add: one conditional add plus one right shift per clock. Each iteration uses a WIDTH-bit add with carry-out, the same arithmetic as the datapath adder. A start/busy/done handshake lets a controller issue a multiply and collect the 64-bit result.

---
 rtl/shift_add_multiplier.sv | 75 +++++++
 tb/tb_shift_add_multiplier.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned WIDTH x WIDTH multiplier: one conditional add and one
// right shift of the {hi, lo} pair per clock, with a start/busy/done handshake.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
  logic [CW-1:0]    count_q;
  logic             busy_q, done_q;
  logic [WIDTH:0]   sum_d;

  // WIDTH+1-bit sum so the carry can be shifted into hi[MSB]
  always_comb begin
    sum_d = {1'b0, hi_q};
    if (lo_q[0]) sum_d = {1'b0, hi_q} + {1'b0, mcand_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= a;
            hi_q    <= '0;
            lo_q    <= b;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          {hi_q, lo_q} <= {sum_d, lo_q[WIDTH-1:1]};
          count_q      <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {hi_q, lo_q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed vectors, handshake
// corner cases and randomized operands against a plain a*b reference.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int n_cmp = 0;
  int n_err = 0;

  shift_add_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  // Issue one multiply; return product at done, edges from start to done,
  // and number of cycles busy was observed high.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] prod, output int lat, output int bcnt);
    start = 1'b1; a = x; b = y;
    step();
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
    if (busy) bcnt++;
    prod = product;
  endtask

  initial begin
    logic [63:0] p, held;
    int lat, bcnt, k, ndone, gap;
    logic [31:0] ra, rb;

    vt[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vt[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vt[2] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    vt[3] = '{32'd0,          32'h1234_5678,  64'h0};
    vt[4] = '{32'h1234_5678,  32'h0000_0010,  64'h0000_0001_2345_6780};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    step(); step();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", product, 64'd0);
    rst = 1'b0;
    step();

    // Directed table
    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, p, lat, bcnt);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      chk($sformatf("vec%0d_product", i), p, vt[i].exp);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd33);
      step();
      chk($sformatf("vec%0d_idle_busy", i), 64'(busy), 64'd0);
      chk($sformatf("vec%0d_idle_done", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d_hold", i), product, vt[i].exp);
      step();
    end

    // start held high; operands change mid-run and must not be resampled
    start = 1'b1; a = 32'd7; b = 32'd6;
    step();
    a = 32'd9; b = 32'd9;
    k = 0;
    while (!done && k < 100) begin step(); k++; end
    chk("hold_first_latency", 64'(k), 64'd32);
    chk("hold_first_product", product, 64'd42);
    ndone = 1; gap = 0;
    step(); gap++;
    while (!done && gap < 100) begin step(); gap++; end
    // the DONE->IDLE handoff puts the second done 33 or 34 edges later
    n_cmp++;
    if (gap != 33 && gap != 34) begin
      n_err++;
      $display("FAIL hold_second_gap: got %0d expected 33 or 34", gap);
    end
    chk("hold_second_product", product, 64'd81);
    start = 1'b0;
    step();
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      step();
    end
    chk("hold_no_extra_done", 64'(ndone), 64'd1);

    // Reset mid-run discards the operation
    start = 1'b1; a = 32'd100; b = 32'd200;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", product, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      step();
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    run_op(32'd100, 32'd200, p, lat, bcnt);
    chk("midrst_fresh_product", p, 64'd20000);
    chk("midrst_fresh_latency", 64'(lat), 64'd32);
    step(); step();

    // Reset and start together: reset wins
    rst = 1'b1; start = 1'b1; a = 32'd5; b = 32'd5;
    step();
    rst = 1'b0; start = 1'b0;
    step();
    chk("rst_start_busy", 64'(busy), 64'd0);
    chk("rst_start_product", product, 64'd0);

    // Randomized operands with random spacing
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 50 == 0) ra = 32'hFFFF_FFFF;
      if (i % 70 == 0) rb = '0;
      run_op(ra, rb, p, lat, bcnt);
      held = ref_mul(ra, rb);
      chk($sformatf("rand%0d_product", i), p, held);
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd32);
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        step();
        if (done) chk($sformatf("rand%0d_spurious_done", i), 64'(done), 64'd0);
      end
      chk($sformatf("rand%0d_hold", i), product, held);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
